dp_sequencer: RTL and testbench
===============================

DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 Parameters SHALL be: M, default 3, register address width; N, default 8, data width; OP_ADD, default 3'b000, ALU add code; OP_PASSA, default 3'b111, ALU pass-A code.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin execution from IDLE.
REQ-005 imem_addr  out  8  instruction address (pc).
REQ-006 imem_data  in  16  instruction word, valid one cycle after imem_addr is presented.
REQ-007 in_valid / in_ready  in / out  1 each  handshake for external data on the datapath din.
REQ-008 out_valid / out_ready  out / in  1 each  handshake for datapath dout.
REQ-009 z_flag, n_flag, o_flag  in  1 each  datapath flags; o_flag is unused.
REQ-010 waddr, ra, rb  out  M each  register addresses to datapath.
REQ-011 op  out  3  ALU operation.
REQ-012 ie, write, reada, readb, en, oe, bypassa, bypassb  out  1 each  datapath controls.
REQ-013 offset  out  N  immediate to datapath.
REQ-014 busy, halted  out  1 each  status.

Function
REQ-015 Instruction fields SHALL be: opc=[15:12], rd=[11:9], ra=[8:6], rb=[5:3], imm6=[5:0], tgt=[7:0].
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WAIT_IN, WAIT_OUT, HALT.
REQ-017 In IDLE, start=1 SHALL go to FETCH; start is ignored in all other states.
REQ-018 FETCH SHALL drive imem_addr=pc.
REQ-019 DECODE SHALL load ir<=imem_data and pc<=pc+1, with 8-bit wrap 0xFF->0x00.
REQ-020 Transition rules: FETCH->DECODE->EXEC; EXEC->FETCH except for IN, OUT and HALT.
REQ-021 opc 0xxx (ALU) in EXEC: ra, rb from ir; reada=readb=1; op=opc[2:0]; en=1; write=1; waddr=rd; one cycle, three cycles total per instruction.
REQ-022 opc 1000 (ADDI) in EXEC: reada=1; bypassb=1; offset=sign-extended imm6 to N bits; op=OP_ADD; en=1; write=1; waddr=rd.
REQ-023 opc 1001 (IN): EXEC->WAIT_IN; WAIT_IN drives in_ready=1 and waddr=rd.
REQ-024 In WAIT_IN, ie=write=in_valid; on in_valid=1 the state SHALL go to FETCH, otherwise hold.
REQ-025 opc 1010 (OUT): EXEC->WAIT_OUT; WAIT_OUT drives ra, reada=1, op=OP_PASSA, oe=1, out_valid=1.
REQ-026 In WAIT_OUT, out_ready=1 SHALL go to FETCH; out_valid SHALL hold until accepted.
REQ-027 opc 1011 JMP SHALL set pc<=tgt in EXEC.
REQ-028 opc 1100 BZ SHALL set pc<=tgt if z_flag=1 in EXEC; opc 1101 BN does the same on n_flag; otherwise pc is unchanged.
REQ-029 opc 1110 NOP SHALL drive no datapath control.
REQ-030 opc 1111 HALT: EXEC->HALT; HALT is held until rst, with halted=1.
REQ-031 In every state/opcode not listed above, all datapath controls SHALL be 0 and addresses/offset SHALL be 0.
REQ-032 Control outputs SHALL depend only on state and ir, except ie/write in WAIT_IN.
REQ-033 busy SHALL be 1 in all states except IDLE and HALT.

Reset
REQ-034 rst=1 at a clock edge SHALL set state=IDLE, pc=0, ir=0, regardless of current state, including WAIT_IN/WAIT_OUT.
REQ-035 After reset, all outputs SHALL be 0: controls, addresses, offset, op, in_ready, out_valid, busy, halted.
REQ-036 A pending in/out handshake SHALL be abandoned on reset without a write.
REQ-037 rst SHALL take priority over start.

Verification
REQ-038 Reset then start; pc0 has 0x0_2_0_1_0 (rd=2, ra=0, rb=1, opc=ADD): EXEC cycle shows reada=readb=en=write=1, waddr=2, ra=0, rb=1, op=000; next cycle FETCH with imem_addr=1.
REQ-039 ADDI rd=3, ra=1, imm6=6'b111110 -> EXEC shows bypassb=1, offset=8'hFE, op=OP_ADD, write=1, waddr=3.
REQ-040 IN rd=4 with in_valid held low 5 cycles then high -> in_ready high for 6 cycles; write=ie=1 only in the final cycle; then FETCH.
REQ-041 OUT ra=2 with out_ready low 3 cycles -> out_valid=oe=1 held 4 cycles; FETCH follows acceptance.
REQ-042 BZ tgt=0x40 with z_flag=1 -> next imem_addr=0x40; with z_flag=0 -> next imem_addr is pc+1. JMP at 0xFF with tgt ignored is not tested; a NOP at 0xFF -> next fetch address 0x00.
REQ-043 rst asserted in WAIT_OUT -> next cycle out_valid=oe=0, busy=0, pc=0; HALT instruction -> halted=1 held, and start has no effect.

Source files
------------

// File: rtl/dp_sequencer_if.sv
// Sequencer <-> datapath/instruction-memory bundle.
// master: the sequencer (drives pc, register addresses, ALU op, datapath controls, handshake outputs).
// slave : the datapath/memory side (drives instruction word, flags, in_valid, out_ready).
interface dp_sequencer_if #(
  parameter int unsigned M = 3,
  parameter int unsigned N = 8
) ();
  logic [7:0]   imem_addr;
  logic [15:0]  imem_data;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic         z_flag;
  logic         n_flag;
  logic         o_flag;
  logic [M-1:0] waddr;
  logic [M-1:0] ra;
  logic [M-1:0] rb;
  logic [2:0]   op;
  logic         ie;
  logic         write;
  logic         reada;
  logic         readb;
  logic         en;
  logic         oe;
  logic         bypassa;
  logic         bypassb;
  logic [N-1:0] offset;

  modport master (
    output imem_addr, in_ready, out_valid, waddr, ra, rb, op,
           ie, write, reada, readb, en, oe, bypassa, bypassb, offset,
    input  imem_data, in_valid, out_ready, z_flag, n_flag, o_flag
  );

  modport slave (
    input  imem_addr, in_ready, out_valid, waddr, ra, rb, op,
           ie, write, reada, readb, en, oe, bypassa, bypassb, offset,
    output imem_data, in_valid, out_ready, z_flag, n_flag, o_flag
  );
endinterface

// File: rtl/dp_sequencer.sv
// Microsequencer: fetches 16-bit instructions, decodes them into datapath
// control, handles external in/out handshakes, branches and halt.
// Ports:
//   clk, rst   - single clock, synchronous active-high reset
//   start      - leave IDLE and begin fetching at pc
//   bus        - instruction memory, datapath controls/addresses, handshakes, flags
//   busy       - 1 in every state except IDLE and HALT
//   halted     - 1 while in HALT
module dp_sequencer #(
  parameter int unsigned M        = 3,
  parameter int unsigned N        = 8,
  parameter logic [2:0]  OP_ADD   = 3'b000,
  parameter logic [2:0]  OP_PASSA = 3'b111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  dp_sequencer_if.master  bus,
  output logic            busy,
  output logic            halted
);

  localparam logic [3:0] OPC_ADDI = 4'b1000;
  localparam logic [3:0] OPC_IN   = 4'b1001;
  localparam logic [3:0] OPC_OUT  = 4'b1010;
  localparam logic [3:0] OPC_JMP  = 4'b1011;
  localparam logic [3:0] OPC_BZ   = 4'b1100;
  localparam logic [3:0] OPC_BN   = 4'b1101;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WAIT_IN, WAIT_OUT, HALT
  } state_t;

  state_t      state, state_next;
  logic [7:0]  pc, pc_next;
  logic [15:0] ir, ir_next;

  // Instruction fields
  logic [3:0] opc;
  logic [2:0] rd_f, ra_f, rb_f;
  logic [5:0] imm6;
  logic [7:0] tgt;

  assign opc  = ir[15:12];
  assign rd_f = ir[11:9];
  assign ra_f = ir[8:6];
  assign rb_f = ir[5:3];
  assign imm6 = ir[5:0];
  assign tgt  = ir[7:0];

  // Overflow flag has no consumer in this instruction set.
  logic unused_o_flag;
  assign unused_o_flag = bus.o_flag;

  // State, pc and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= 8'h00;
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  // Next-state, pc and ir update
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      IDLE:   if (start) state_next = FETCH;
      FETCH:  state_next = DECODE;
      DECODE: begin
        ir_next    = bus.imem_data;
        pc_next    = pc + 8'd1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (opc)
          OPC_IN:   state_next = WAIT_IN;
          OPC_OUT:  state_next = WAIT_OUT;
          OPC_HALT: state_next = HALT;
          OPC_JMP:  pc_next = tgt;
          OPC_BZ:   if (bus.z_flag) pc_next = tgt;
          OPC_BN:   if (bus.n_flag) pc_next = tgt;
          default:  ;
        endcase
      end
      WAIT_IN:  if (bus.in_valid)  state_next = FETCH;
      WAIT_OUT: if (bus.out_ready) state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath control decode; only WAIT_IN looks at an input (in_valid)
  always_comb begin
    bus.imem_addr = pc;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.waddr     = '0;
    bus.ra        = '0;
    bus.rb        = '0;
    bus.op        = 3'b000;
    bus.ie        = 1'b0;
    bus.write     = 1'b0;
    bus.reada     = 1'b0;
    bus.readb     = 1'b0;
    bus.en        = 1'b0;
    bus.oe        = 1'b0;
    bus.bypassa   = 1'b0;
    bus.bypassb   = 1'b0;
    bus.offset    = '0;
    busy          = (state != IDLE) && (state != HALT);
    halted        = (state == HALT);
    case (state)
      EXEC: begin
        if (!opc[3]) begin
          bus.ra    = M'(ra_f);
          bus.rb    = M'(rb_f);
          bus.reada = 1'b1;
          bus.readb = 1'b1;
          bus.op    = opc[2:0];
          bus.en    = 1'b1;
          bus.write = 1'b1;
          bus.waddr = M'(rd_f);
        end else if (opc == OPC_ADDI) begin
          bus.ra      = M'(ra_f);
          bus.reada   = 1'b1;
          bus.bypassb = 1'b1;
          bus.offset  = N'($signed(imm6));
          bus.op      = OP_ADD;
          bus.en      = 1'b1;
          bus.write   = 1'b1;
          bus.waddr   = M'(rd_f);
        end
      end
      WAIT_IN: begin
        bus.in_ready = 1'b1;
        bus.waddr    = M'(rd_f);
        bus.ie       = bus.in_valid;
        bus.write    = bus.in_valid;
      end
      WAIT_OUT: begin
        bus.ra        = M'(ra_f);
        bus.reada     = 1'b1;
        bus.op        = OP_PASSA;
        bus.oe        = 1'b1;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: registered instruction memory model,
// hand-computed expectations checked on the falling clock edge.
module tb_dp_sequencer;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic halted;

  int checks = 0;
  int passes = 0;

  logic [15:0] mem [256];

  dp_sequencer_if #(.M(3), .N(8)) bus ();

  dp_sequencer #(.M(3), .N(8), .OP_ADD(3'b000), .OP_PASSA(3'b111)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word is valid one cycle after the address
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  // {ie, write, reada, readb, en, oe, bypassa, bypassb}
  logic [7:0] ctl;
  assign ctl = {bus.ie, bus.write, bus.reada, bus.readb,
                bus.en, bus.oe, bus.bypassa, bus.bypassb};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) passes = passes + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    mem[8'h00] = 16'h0408;  // ADD  rd=2 ra=0 rb=1
    mem[8'h01] = 16'h867E;  // ADDI rd=3 ra=1 imm=-2
    mem[8'h02] = 16'h9800;  // IN   rd=4
    mem[8'h03] = 16'hA080;  // OUT  ra=2
    mem[8'h04] = 16'hC040;  // BZ   0x40
    mem[8'h40] = 16'hC080;  // BZ   0x80 (not taken)
    mem[8'h41] = 16'hB0FF;  // JMP  0xFF
    mem[8'hFF] = 16'hE000;  // NOP

    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.z_flag = 1'b0; bus.n_flag = 1'b0; bus.o_flag = 1'b0;
    cyc(2);
    chk("rst_ctl", 32'(ctl), 32'h00);
    chk("rst_pc", 32'(bus.imem_addr), 32'h00);
    chk("rst_status", 32'({busy, halted, bus.in_ready, bus.out_valid}), 32'h0);
    chk("rst_addr", 32'({bus.waddr, bus.ra, bus.rb, bus.op, bus.offset}), 32'h0);

    rst = 1'b0; start = 1'b1;
    cyc(1);                       // FETCH pc=0
    start = 1'b0;
    chk("fetch0_addr", 32'(bus.imem_addr), 32'h00);
    chk("fetch0_busy", 32'(busy), 32'h1);
    cyc(2);                       // EXEC ADD
    chk("add_ctl", 32'(ctl), 32'h78);
    chk("add_addr", 32'({bus.waddr, bus.ra, bus.rb}), 32'({3'd2, 3'd0, 3'd1}));
    chk("add_op", 32'(bus.op), 32'h0);
    cyc(1);
    chk("fetch1_addr", 32'(bus.imem_addr), 32'h01);
    chk("fetch1_ctl", 32'(ctl), 32'h00);

    cyc(2);                       // EXEC ADDI
    chk("addi_ctl", 32'(ctl), 32'h69);
    chk("addi_offset", 32'(bus.offset), 32'hFE);
    chk("addi_waddr", 32'(bus.waddr), 32'h3);
    chk("addi_ra", 32'(bus.ra), 32'h1);
    chk("addi_op", 32'(bus.op), 32'h0);

    cyc(3);                       // EXEC IN
    chk("in_exec_rdy", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);                     // WAIT_IN, no data yet
      chk("in_wait_rdy", 32'(bus.in_ready), 32'h1);
      chk("in_wait_ctl", 32'(ctl), 32'h00);
      chk("in_wait_waddr", 32'(bus.waddr), 32'h4);
    end
    cyc(1);
    bus.in_valid = 1'b1;
    #1;
    chk("in_take_rdy", 32'(bus.in_ready), 32'h1);
    chk("in_take_ctl", 32'(ctl), 32'hC0);
    cyc(1);
    bus.in_valid = 1'b0;
    #1;
    chk("in_done_addr", 32'(bus.imem_addr), 32'h03);
    chk("in_done_rdy", 32'(bus.in_ready), 32'h0);

    cyc(2);                       // EXEC OUT
    chk("out_exec_vld", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);                     // WAIT_OUT, not accepted
      chk("out_wait_ctl", 32'(ctl), 32'h24);
      chk("out_wait_vld", 32'(bus.out_valid), 32'h1);
      chk("out_wait_ra_op", 32'({bus.ra, bus.op}), 32'({3'd2, 3'b111}));
    end
    cyc(1);
    bus.out_ready = 1'b1;
    chk("out_acc_vld", 32'(bus.out_valid), 32'h1);
    cyc(1);
    bus.out_ready = 1'b0;
    bus.z_flag = 1'b1;
    chk("out_done_addr", 32'(bus.imem_addr), 32'h04);
    chk("out_done_vld", 32'(bus.out_valid), 32'h0);

    cyc(3);                       // BZ taken
    bus.z_flag = 1'b0;
    chk("bz_taken", 32'(bus.imem_addr), 32'h40);
    cyc(3);                       // BZ not taken
    chk("bz_not_taken", 32'(bus.imem_addr), 32'h41);
    cyc(3);                       // JMP 0xFF
    chk("jmp_ff", 32'(bus.imem_addr), 32'hFF);
    cyc(2);                       // EXEC NOP
    chk("nop_ctl", 32'(ctl), 32'h00);
    chk("nop_addr", 32'({bus.waddr, bus.ra, bus.rb, bus.op, bus.offset}), 32'h0);
    cyc(1);
    chk("pc_wrap", 32'(bus.imem_addr), 32'h00);

    // Reset while an output handshake is pending
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    mem[8'h00] = 16'hA080;        // OUT ra=2
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);                       // WAIT_OUT
    chk("wo_vld", 32'(bus.out_valid), 32'h1);
    cyc(1);
    rst = 1'b1; start = 1'b1;     // reset wins over start
    cyc(1);
    chk("wo_rst_vld_oe", 32'({bus.out_valid, bus.oe}), 32'h0);
    chk("wo_rst_busy", 32'(busy), 32'h0);
    chk("wo_rst_pc", 32'(bus.imem_addr), 32'h00);
    rst = 1'b0; start = 1'b0;
    cyc(1);
    chk("wo_idle_busy", 32'(busy), 32'h0);

    // Reset while an input handshake is pending: no write on abandon
    mem[8'h00] = 16'h9800;        // IN rd=4
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);                       // WAIT_IN
    chk("wi_rdy", 32'(bus.in_ready), 32'h1);
    rst = 1'b1;
    cyc(1);
    bus.in_valid = 1'b1;
    #1;
    chk("wi_rst_ctl", 32'(ctl), 32'h00);
    chk("wi_rst_rdy", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // BN taken into HALT; start must not leave HALT
    mem[8'h00] = 16'hD010;        // BN 0x10
    mem[8'h10] = 16'hF000;        // HALT
    bus.n_flag = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    bus.n_flag = 1'b0;
    chk("bn_taken", 32'(bus.imem_addr), 32'h10);
    cyc(2);                       // EXEC HALT
    chk("halt_exec", 32'({busy, halted}), 32'h2);
    cyc(1);
    chk("halt_state", 32'({busy, halted}), 32'h1);
    start = 1'b1;
    cyc(3);
    chk("halt_hold", 32'({busy, halted}), 32'h1);
    chk("halt_pc", 32'(bus.imem_addr), 32'h11);
    chk("halt_ctl", 32'(ctl), 32'h00);
    start = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk("halt_rst", 32'({busy, halted}), 32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
